// File: rtl/timing_gen_if.sv
// Timing bus between the machine-cycle timing generator and its consumers
// (address decode, control unit). The generator drives the timing outputs and
// samples the decode/halt/memory-ready inputs.
interface timing_gen_if;
  logic [1:0] cyc_len;
  logic       halt;
  logic       mem_ready;
  logic [2:0] S;
  logic       Phase;
  logic [1:0] cycles;
  logic       ALE;
  logic       mc_end;
  logic       idle;

  modport master (
    input  cyc_len, halt, mem_ready,
    output S, Phase, cycles, ALE, mc_end, idle
  );

  modport slave (
    output cyc_len, halt, mem_ready,
    input  S, Phase, cycles, ALE, mc_end, idle
  );
endinterface

// File: rtl/timing_gen.sv
// 8051 machine-cycle timing generator.
// Sequences S1..S6 with two phases each (12 phases per machine cycle), tracks the
// machine cycles remaining in the current instruction, and emits ALE, an
// end-of-machine-cycle strobe and an idle flag for halt.
// Optional feature macro: WAIT_STATE_EN -- when defined, S3P2 is stretched while
// mem_ready is low. When undefined, mem_ready is ignored.
//
// state | meaning
// ------+---------------------------------------------
// S1    | 001  address phase, ALE in P2
// S2    | 011
// S3    | 010  memory access, optional wait in P2
// S4    | 000  second ALE in P2
// S5    | 100
// S6    | 101  P2 is the machine-cycle boundary
module timing_gen #(
  parameter int PHASE_DIV = 1,
  parameter int DIV_W     = 4
) (
  input logic          clk,
  input logic          rst_n,
  timing_gen_if.master bus
);

  typedef enum logic [2:0] {
    ST_S1 = 3'b001,
    ST_S2 = 3'b011,
    ST_S3 = 3'b010,
    ST_S4 = 3'b000,
    ST_S5 = 3'b100,
    ST_S6 = 3'b101
  } s_code_t;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PHASE_DIV - 1);
  localparam logic [DIV_W-1:0] PRESC_ONE = DIV_W'(1);

  s_code_t          s_q, s_d;
  logic             phase_q, phase_d;
  logic [1:0]       cycles_q, cycles_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             idle_q, idle_d;
  logic             ale_q, ale_d;
  logic             mc_end_q, mc_end_d;
  logic             tick;
  logic             wait_hold;
  logic             s_legal;

`ifndef WAIT_STATE_EN
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
`endif

  // Next-state decode: prescaler, S/Phase sequencing, cycle count, halt freeze.
  always_comb begin
    s_d       = s_q;
    phase_d   = phase_q;
    cycles_d  = cycles_q;
    presc_d   = presc_q;
    idle_d    = idle_q;
    tick      = (presc_q == DIV_LAST);
    wait_hold = 1'b0;
    s_legal   = s_q inside {ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6};

`ifdef WAIT_STATE_EN
    // Stretch S3P2 one tick at a time until memory is ready.
    wait_hold = tick && (s_q == ST_S3) && phase_q && !bus.mem_ready;
`endif

    if (idle_q) begin
      // Frozen at S1P1; leaving idle restarts the prescaler so S1P1 gets a full phase.
      presc_d = '0;
      if (!bus.halt) begin
        idle_d = 1'b0;
      end
    end else begin
      presc_d = tick ? '0 : (presc_q + PRESC_ONE);
      if (tick && !wait_hold) begin
        if (!s_legal) begin
          s_d     = ST_S1;
          phase_d = 1'b0;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          case (s_q)
            ST_S1:   s_d = ST_S2;
            ST_S2:   s_d = ST_S3;
            ST_S3:   s_d = ST_S4;
            ST_S4:   s_d = ST_S5;
            ST_S5:   s_d = ST_S6;
            ST_S6: begin
              s_d    = ST_S1;
              idle_d = bus.halt;
              case (cycles_q)
                2'b00:   cycles_d = bus.cyc_len;
                2'b11:   cycles_d = 2'b00;
                default: cycles_d = cycles_q - 2'd1;
              endcase
            end
            default: s_d = ST_S1;
          endcase
        end
      end
    end

    // Strobes are decoded from the next state so they line up with S/Phase.
    ale_d    = !idle_d && phase_d && ((s_d == ST_S1) || (s_d == ST_S4));
    mc_end_d = !idle_d && phase_d && (s_d == ST_S6) && (presc_d == DIV_LAST);
  end

  // State and registered strobes, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q      <= ST_S1;
      phase_q  <= 1'b0;
      cycles_q <= 2'b11;
      presc_q  <= '0;
      idle_q   <= 1'b0;
      ale_q    <= 1'b0;
      mc_end_q <= 1'b0;
    end else begin
      s_q      <= s_d;
      phase_q  <= phase_d;
      cycles_q <= cycles_d;
      presc_q  <= presc_d;
      idle_q   <= idle_d;
      ale_q    <= ale_d;
      mc_end_q <= mc_end_d;
    end
  end

  assign bus.S      = s_q;
  assign bus.Phase  = phase_q;
  assign bus.cycles = cycles_q;
  assign bus.ALE    = ale_q;
  assign bus.mc_end = mc_end_q;
  assign bus.idle   = idle_q;

endmodule
